// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache request port between the core memory stage and the PTW.
// One transaction in flight at a time; PTW wins arbitration unless the core has been starved.
module dcache_port_arbiter #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_req_valid,
   input  logic [63:0] core_req_addr,
   input  logic        core_req_write,
   input  logic [63:0] core_req_wdata,
   output logic        core_req_ready,
   output logic        core_resp_valid,
   output logic [63:0] core_resp_data,
   input  logic        ptw_req_valid,
   input  logic [63:0] ptw_req_addr,
   output logic        ptw_resp_valid,
   output logic [63:0] ptw_resp_data,
   output logic        dc_req_valid,
   output logic [63:0] dc_req_addr,
   output logic        dc_req_write,
   output logic [63:0] dc_req_wdata,
   output logic        dc_req_phys,
   input  logic        dc_req_ready,
   input  logic        dc_resp_valid,
   input  logic [63:0] dc_resp_data,
   output logic        protocol_err
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] CORE_OUT = 2'd1;
   localparam logic [1:0] PTW_OUT  = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [CW-1:0] starve_cnt;
   logic          idle;
   logic          grant_ptw;
   logic          grant_core;
   logic          accept;

   assign idle       = (state == IDLE);
   assign grant_ptw  = idle && ptw_req_valid && !(core_req_valid && starve_cnt == LIMIT);
   assign grant_core = idle && core_req_valid && !grant_ptw;

   assign dc_req_valid   = grant_ptw | grant_core;
   assign dc_req_phys    = grant_ptw;
   assign dc_req_addr    = grant_ptw ? ptw_req_addr : (grant_core ? core_req_addr : 64'd0);
   assign dc_req_write   = grant_core & core_req_write;
   assign dc_req_wdata   = grant_core ? core_req_wdata : 64'd0;
   assign core_req_ready = grant_core & dc_req_ready;
   assign accept         = dc_req_valid & dc_req_ready;

   // A PTW that dropped its request during the response cycle has aborted; swallow the data.
   assign core_resp_valid = (state == CORE_OUT) & dc_resp_valid;
   assign ptw_resp_valid  = (state == PTW_OUT) & dc_resp_valid & ptw_req_valid;
   assign core_resp_data  = core_resp_valid ? dc_resp_data : 64'd0;
   assign ptw_resp_data   = ptw_resp_valid ? dc_resp_data : 64'd0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:              if (accept) state_nxt = grant_ptw ? PTW_OUT : CORE_OUT;
         CORE_OUT, PTW_OUT: if (dc_resp_valid) state_nxt = IDLE;
         default:           state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         starve_cnt   <= '0;
         protocol_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (!core_req_valid || (accept && grant_core))
            starve_cnt <= '0;
         else if (accept && grant_ptw && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
         if (idle && dc_resp_valid)
            protocol_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomised bench for dcache_port_arbiter: a transaction-level model predicts grants,
// and a scoreboard of expected responses is drained by an independent monitor.
module tb_dcache_port_arbiter;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req_valid, core_req_write, core_req_ready, core_resp_valid;
   logic [63:0] core_req_addr, core_req_wdata, core_resp_data;
   logic        ptw_req_valid, ptw_resp_valid;
   logic [63:0] ptw_req_addr, ptw_resp_data;
   logic        dc_req_valid, dc_req_write, dc_req_phys, dc_req_ready, dc_resp_valid;
   logic [63:0] dc_req_addr, dc_req_wdata, dc_resp_data;
   logic        protocol_err;

   always #5 clk = ~clk;

   dcache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .core_req_valid(core_req_valid), .core_req_addr(core_req_addr),
      .core_req_write(core_req_write), .core_req_wdata(core_req_wdata),
      .core_req_ready(core_req_ready), .core_resp_valid(core_resp_valid),
      .core_resp_data(core_resp_data),
      .ptw_req_valid(ptw_req_valid), .ptw_req_addr(ptw_req_addr),
      .ptw_resp_valid(ptw_resp_valid), .ptw_resp_data(ptw_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_write(dc_req_write),
      .dc_req_wdata(dc_req_wdata), .dc_req_phys(dc_req_phys), .dc_req_ready(dc_req_ready),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .protocol_err(protocol_err)
   );

   typedef struct { bit is_ptw; logic [63:0] data; int cyc; } exp_t;
   exp_t sb[$];
   bit   log_ptw[$];

   int tests = 0, fails = 0, cyc = 0, core_pulses = 0;

   // requester / cache model state
   bit          core_pend, ptw_pend, c_write;
   logic [63:0] c_addr, c_wdata, p_addr;
   bit          busy, busy_ptw, out_now, perr, perr_next;
   int          resp_wait, ptw_wins;
   logic [63:0] resp_dat;

   // stimulus knobs (percentages / delays)
   int k_core, k_ptw, k_ready, k_dmin, k_dmax, k_abort, k_spur;
   bit k_fix;
   logic [63:0] k_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic drive_cycle();
      cyc++;
      if (!core_pend && $urandom_range(99) < k_core) begin
         core_pend = 1; c_addr = {$urandom, $urandom}; c_write = $urandom_range(1);
         c_wdata = {$urandom, $urandom};
      end
      if (!ptw_pend && $urandom_range(99) < k_ptw) begin
         ptw_pend = 1; p_addr = {$urandom, $urandom} & ~64'h7;
      end
      core_req_valid = core_pend; core_req_addr = c_addr;
      core_req_write = c_write;   core_req_wdata = c_wdata;
      ptw_req_valid  = ptw_pend;  ptw_req_addr  = p_addr;
      dc_req_ready   = ($urandom_range(99) < k_ready);
      dc_resp_valid  = 0;
      dc_resp_data   = {$urandom, $urandom};
      perr_next      = 0;
      out_now        = busy;
      if (busy) begin
         if (resp_wait == 0) begin
            dc_resp_valid = 1; dc_resp_data = resp_dat; busy = 0;
            if (busy_ptw) begin
               if ($urandom_range(99) < k_abort) ptw_req_valid = 0;
               else sb.push_back('{1'b1, resp_dat, cyc});
               ptw_pend = 0;
            end else
               sb.push_back('{1'b0, resp_dat, cyc});
         end else
            resp_wait--;
      end else if ($urandom_range(99) < k_spur) begin
         dc_resp_valid = 1; perr_next = 1;
      end
   endtask

   task automatic sample_cycle();
      bit gp, gc;
      if (out_now) begin
         chk("busy_req_valid", dc_req_valid, 0);
         chk("busy_core_ready", core_req_ready, 0);
      end else begin
         gp = ptw_req_valid && !(core_req_valid && ptw_wins == LIMIT);
         gc = core_req_valid && !gp;
         chk("req_valid", dc_req_valid, gp | gc);
         chk("req_phys", dc_req_phys, gp);
         chk("core_ready", core_req_ready, gc && dc_req_ready);
         if (gp) begin
            chk("ptw_addr", dc_req_addr, p_addr);
            chk("ptw_write", dc_req_write, 0);
            chk("ptw_wdata", dc_req_wdata, 0);
         end else if (gc) begin
            chk("core_addr", dc_req_addr, c_addr);
            chk("core_write", dc_req_write, c_write);
            chk("core_wdata", dc_req_wdata, c_wdata);
         end
         if ((gp || gc) && dc_req_ready) begin
            busy = 1; busy_ptw = gp;
            resp_wait = $urandom_range(k_dmax, k_dmin);
            resp_dat  = k_fix ? k_data : {$urandom, $urandom};
            log_ptw.push_back(gp);
            if (gc) begin core_pend = 0; ptw_wins = 0; end
            else if (core_req_valid && ptw_wins < LIMIT) ptw_wins++;
         end
      end
      if (!core_req_valid) ptw_wins = 0;
      chk("protocol_err", protocol_err, perr);
      perr = perr | perr_next;
   endtask

   task automatic cycle();
      @(posedge clk); #1;
      drive_cycle();
      @(negedge clk);
      sample_cycle();
   endtask

   task automatic knobs(input int c, p, r, dmin, dmax, ab, sp);
      k_core = c; k_ptw = p; k_ready = r; k_dmin = dmin; k_dmax = dmax; k_abort = ab; k_spur = sp;
   endtask

   // response monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (core_resp_valid) core_pulses++;
      if (core_resp_valid || ptw_resp_valid) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_resp cyc=%0d core=%b ptw=%b", cyc, core_resp_valid, ptw_resp_valid);
         end else begin
            e = sb.pop_front();
            chk("resp_owner_ptw", ptw_resp_valid, e.is_ptw);
            chk("resp_owner_core", core_resp_valid, !e.is_ptw);
            chk("resp_data", e.is_ptw ? ptw_resp_data : core_resp_data, e.data);
            chk("nonowner_data", e.is_ptw ? core_resp_data : ptw_resp_data, 0);
         end
      end else begin
         chk("idle_core_data", core_resp_data, 0);
         chk("idle_ptw_data", ptw_resp_data, 0);
         if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tests++; fails++;
            $display("FAIL missing_resp cyc=%0d got=none want=%s data %h", cyc,
                     e.is_ptw ? "ptw" : "core", e.data);
         end
      end
   end

   initial begin
      reset = 1;
      core_req_valid = 0; core_req_addr = 0; core_req_write = 0; core_req_wdata = 0;
      ptw_req_valid = 0; ptw_req_addr = 0; dc_req_ready = 0; dc_resp_valid = 0; dc_resp_data = 0;
      core_pend = 0; ptw_pend = 0; busy = 0; perr = 0; ptw_wins = 0; k_fix = 0; k_data = 0;
      c_addr = 0; c_wdata = 0; c_write = 0; p_addr = 0;
      knobs(0, 0, 100, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_req_valid", dc_req_valid, 0);
      chk("rst_core_ready", core_req_ready, 0);
      chk("rst_resp", {core_resp_valid, ptw_resp_valid}, 0);
      chk("rst_perr", protocol_err, 0);

      // reset while a PTW read is outstanding; the late response must be dropped
      @(posedge clk); #1;
      reset = 0; ptw_req_valid = 1; ptw_req_addr = 64'h2008; dc_req_ready = 1;
      @(negedge clk);
      chk("rp_grant_ptw", dc_req_phys, 1);
      @(posedge clk); #1;
      dc_req_ready = 0;
      @(negedge clk);
      chk("rp_in_ptw_out", dc_req_valid, 0);
      #1 reset = 1; #2 reset = 0;
      @(posedge clk); #1;
      dc_resp_valid = 1; dc_resp_data = 64'h55;
      @(negedge clk);
      chk("rp_no_ptw_resp", ptw_resp_valid, 0);
      chk("rp_no_core_resp", core_resp_valid, 0);
      chk("rp_idle_again", dc_req_valid, 1);
      @(posedge clk); #1;
      dc_resp_valid = 0; ptw_req_valid = 0;
      @(negedge clk);
      chk("rp_perr_set", protocol_err, 1);
      #1 reset = 1;
      @(negedge clk);
      chk("rp_perr_clear", protocol_err, 0);
      #1 reset = 0;

      // single core load, response two cycles after accept
      core_pend = 1; c_addr = 64'h1000; c_write = 0; c_wdata = 0;
      knobs(0, 0, 100, 1, 1, 0, 0); k_fix = 1; k_data = 64'hAB;
      core_pulses = 0;
      cycle();
      chk("load_accept", core_req_ready, 1);
      chk("load_phys", dc_req_phys, 0);
      repeat (4) cycle();
      chk("load_one_pulse", core_pulses, 1);
      k_fix = 0;

      // simultaneous requests, then sustained contention to exercise starvation bound
      core_pend = 1; c_addr = 64'hC0DE_0000; c_write = 1; c_wdata = 64'hFFFF;
      ptw_pend = 1; p_addr = 64'h8000;
      log_ptw.delete();
      knobs(100, 100, 100, 0, 0, 0, 0);
      cycle();
      chk("both_phys", dc_req_phys, 1);
      chk("both_write", dc_req_write, 0);
      chk("both_core_ready", core_req_ready, 0);
      repeat (40) cycle();
      chk("starve_log_len", log_ptw.size() >= 18, 1);
      for (int i = 0; i < 18 && i < log_ptw.size(); i++)
         chk($sformatf("starve_order%0d", i), log_ptw[i], (i % 9) != 8);
      knobs(0, 0, 100, 0, 0, 0, 0);
      repeat (12) cycle();

      // cache stalls for five cycles with the core waiting
      core_pend = 1; c_addr = 64'h4440; c_write = 0; c_wdata = 0;
      knobs(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_ready_low", core_req_ready, 0);
         chk("stall_still_req", dc_req_valid, 1);
      end
      k_ready = 100;
      cycle();
      chk("stall_accept6", core_req_ready, 1);
      repeat (6) cycle();

      // randomised traffic
      knobs(50, 50, 70, 0, 3, 20, 0); repeat (500) cycle();
      knobs(90, 90, 50, 0, 2, 10, 3); repeat (500) cycle();
      knobs(30, 80, 90, 0, 0, 30, 5); repeat (500) cycle();
      knobs(0, 0, 100, 0, 0, 0, 0);   repeat (20) cycle();
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
